// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between the fetch-stage control logic and pc_unit.
//
// Signals (direction seen from the slave, i.e. pc_unit):
//   stall          in   hold PC (hazard unit)
//   redirect_valid in   take redirect_pc next cycle
//   redirect_pc    in   branch/jump target
//   trap_valid     in   take trap_vector next cycle
//   trap_vector    in   trap handler address
//   call_valid     in   call: push pc+INC, jump to call_target
//   call_target    in   call destination
//   ret_valid      in   return: pop RAS, jump to popped address
//   ret_fallback   in   return target used when RAS empty
//   pc             out  current PC (registered)
//   pc_plus_inc    out  pc + INC (combinational, wraps)
//   pc_valid       out  PC is fetchable
//   ras_count      out  live RAS entries
//   ras_underflow  out  1-cycle pulse: ret taken with RAS empty
//
// Modports: master = request side (hazard/branch/trap logic), slave = pc_unit.
// XLEN and RAS_DEPTH must match the parameters of the attached pc_unit.
interface pc_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            call_valid;
    logic [XLEN-1:0] call_target;
    logic            ret_valid;
    logic [XLEN-1:0] ret_fallback;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            pc_valid;
    logic [CW-1:0]   ras_count;
    logic            ras_underflow;

    modport master (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output trap_valid,
        output trap_vector,
        output call_valid,
        output call_target,
        output ret_valid,
        output ret_fallback,
        input  pc,
        input  pc_plus_inc,
        input  pc_valid,
        input  ras_count,
        input  ras_underflow
    );

    modport slave (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  trap_valid,
        input  trap_vector,
        input  call_valid,
        input  call_target,
        input  ret_valid,
        input  ret_fallback,
        output pc,
        output pc_plus_inc,
        output pc_valid,
        output ras_count,
        output ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the fetch stage of the pipelined datapath.
//
// Holds the PC and selects its next value each cycle by fixed priority:
//   trap > redirect > ret > call > stall > sequential (pc + INC).
// A circular return-address stack (RAS) records pc+INC on calls and supplies the
// target on returns; an empty-stack return falls back to ret_fallback and pulses
// ras_underflow. All PC updates are registered (one cycle after the request edge).
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high; overrides every request
//   bus    pc_unit_if.slave -- requests in; pc, pc_plus_inc, pc_valid,
//          ras_count, ras_underflow out
module pc_unit #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int unsigned       INC          = 4,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic      clk,
    input  logic      reset,
    pc_unit_if.slave  bus
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Pointer arithmetic relies on natural wrap of a PW-bit counter.
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_unit: RAS_DEPTH must be a power of two >= 2");
    end

    // Winning next-PC source for this cycle.
    typedef enum logic [2:0] {
        SrcSeq,
        SrcStall,
        SrcCall,
        SrcRet,
        SrcRedirect,
        SrcTrap
    } src_e;

    src_e            src;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus_inc;
    logic            pc_valid_q;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   top_ptr;
    logic [CW-1:0]   count_q, count_d;
    logic            underflow_q, underflow_d;
    logic            push_en;
    logic            ras_empty;
    logic            ras_full;

    assign pc_plus_inc = pc_q + XLEN'(INC);
    assign ras_empty   = (count_q == '0);
    assign ras_full    = (count_q == CW'(RAS_DEPTH));
    // Most recent entry lives just below the write pointer.
    assign top_ptr     = wr_ptr_q - PW'(1);

    // Priority select of the next-PC source.
    always_comb begin
        src = SrcSeq;
        if (bus.trap_valid) begin
            src = SrcTrap;
        end else if (bus.redirect_valid) begin
            src = SrcRedirect;
        end else if (bus.ret_valid) begin
            src = SrcRet;
        end else if (bus.call_valid) begin
            src = SrcCall;
        end else if (bus.stall) begin
            src = SrcStall;
        end
    end

    // Next-state for PC and RAS bookkeeping. The RAS only moves when ret or call
    // is the winning source, so a losing ret/call has no side effect.
    always_comb begin
        pc_d        = pc_plus_inc;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        underflow_d = 1'b0;
        push_en     = 1'b0;
        unique case (src)
            SrcTrap:     pc_d = bus.trap_vector;
            SrcRedirect: pc_d = bus.redirect_pc;
            SrcRet: begin
                if (ras_empty) begin
                    pc_d        = bus.ret_fallback;
                    underflow_d = 1'b1;
                end else begin
                    pc_d     = ras_q[top_ptr];
                    wr_ptr_d = top_ptr;
                    count_d  = count_q - CW'(1);
                end
            end
            SrcCall: begin
                pc_d     = bus.call_target;
                push_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                // When full, the push overwrites the oldest entry (the slot at
                // wr_ptr) and the count saturates.
                if (!ras_full) begin
                    count_d = count_q + CW'(1);
                end
            end
            SrcStall:    pc_d = pc_q;
            SrcSeq:      pc_d = pc_plus_inc;
            default:     pc_d = pc_plus_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            pc_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            if (push_en) begin
                ras_q[wr_ptr_q] <= pc_plus_inc;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus_inc   = pc_plus_inc;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.ras_count     = count_q;
    assign bus.ras_underflow = underflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (RESET_VECTOR = 0x100, depth 4).
module tb_pc_unit;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned RAS_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0100),
        .INC          (4),
        .RAS_DEPTH    (RAS_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic clear_req();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.trap_valid     = 1'b0;
        bus.trap_vector    = '0;
        bus.call_valid     = 1'b0;
        bus.call_target    = '0;
        bus.ret_valid      = 1'b0;
        bus.ret_fallback   = '0;
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        clear_req();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = addr;
        tick();
        clear_req();
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h104;
        exp_seq[1] = 32'h108;
        exp_seq[2] = 32'h10C;
        clear_req();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.pc !== 32'h100) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h100);
        end
        checks++;
        if (bus.pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc_valid: got %b expected 0", bus.pc_valid);
        end
        checks++;
        if (bus.ras_count !== 3'd0 || bus.ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ras: got count %0d uf %b expected 0 0",
                     bus.ras_count, bus.ras_underflow);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.pc !== exp_seq[i] || bus.pc_valid !== 1'b1) begin
                errors++;
                $display("FAIL free_run[%0d]: got pc %h valid %b expected %h 1",
                         i, bus.pc, bus.pc_valid, exp_seq[i]);
            end
        end
    endtask

    task automatic test_priority();
        goto_pc(32'h200);
        checks++;
        if (bus.pc !== 32'h200) begin
            errors++;
            $display("FAIL prio_setup: got %h expected %h", bus.pc, 32'h200);
        end
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        bus.trap_valid     = 1'b1;
        bus.trap_vector    = 32'h80;
        tick();
        checks++;
        if (bus.pc !== 32'h80) begin
            errors++;
            $display("FAIL prio_trap: got %h expected %h", bus.pc, 32'h80);
        end
        clear_req();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        bus.stall          = 1'b1;
        tick();
        checks++;
        if (bus.pc !== 32'h400) begin
            errors++;
            $display("FAIL prio_redirect_over_stall: got %h expected %h", bus.pc, 32'h400);
        end
        goto_pc(32'h80);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.pc !== 32'h80) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, bus.pc, 32'h80);
            end
        end
        clear_req();
    endtask

    task automatic test_call_ret();
        goto_pc(32'h10);
        bus.call_valid  = 1'b1;
        bus.call_target = 32'h500;
        tick();
        clear_req();
        checks++;
        if (bus.pc !== 32'h500 || bus.ras_count !== 3'd1) begin
            errors++;
            $display("FAIL call: got pc %h count %0d expected 500 1", bus.pc, bus.ras_count);
        end
        bus.ret_valid    = 1'b1;
        bus.ret_fallback = 32'h999;
        tick();
        clear_req();
        checks++;
        if (bus.pc !== 32'h14 || bus.ras_count !== 3'd0 || bus.ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL ret: got pc %h count %0d uf %b expected 14 0 0",
                     bus.pc, bus.ras_count, bus.ras_underflow);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h44;
        exp_ret[1] = 32'h34;
        exp_ret[2] = 32'h24;
        exp_ret[3] = 32'h14;
        for (int i = 0; i < 5; i++) begin
            goto_pc(32'(i * 16));
            bus.call_valid  = 1'b1;
            bus.call_target = 32'h500;
            tick();
            clear_req();
        end
        checks++;
        if (bus.ras_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 4", bus.ras_count);
        end
        for (int i = 0; i < 4; i++) begin
            bus.ret_valid    = 1'b1;
            bus.ret_fallback = 32'h999;
            tick();
            checks++;
            if (bus.pc !== exp_ret[i] || bus.ras_count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL ovf_ret[%0d]: got pc %h count %0d expected %h %0d",
                         i, bus.pc, bus.ras_count, exp_ret[i], 3 - i);
            end
        end
        tick();
        clear_req();
        checks++;
        if (bus.pc !== 32'h999 || bus.ras_underflow !== 1'b1 || bus.ras_count !== 3'd0) begin
            errors++;
            $display("FAIL underflow: got pc %h uf %b count %0d expected 999 1 0",
                     bus.pc, bus.ras_underflow, bus.ras_count);
        end
        tick();
        checks++;
        if (bus.ras_underflow !== 1'b0 || bus.pc !== 32'h99D) begin
            errors++;
            $display("FAIL underflow_pulse: got uf %b pc %h expected 0 99d",
                     bus.ras_underflow, bus.pc);
        end
    endtask

    task automatic test_back_to_back();
        goto_pc(32'h40);
        bus.call_valid  = 1'b1;
        bus.call_target = 32'h600;
        tick();
        // redirect beats both ret and call: RAS untouched
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h700;
        bus.ret_valid      = 1'b1;
        bus.call_target    = 32'h800;
        tick();
        clear_req();
        checks++;
        if (bus.pc !== 32'h700 || bus.ras_count !== 3'd1) begin
            errors++;
            $display("FAIL redirect_drops_ras: got pc %h count %0d expected 700 1",
                     bus.pc, bus.ras_count);
        end
        bus.stall       = 1'b1;
        bus.call_valid  = 1'b1;
        bus.call_target = 32'h800;
        tick();
        clear_req();
        checks++;
        if (bus.pc !== 32'h800 || bus.ras_count !== 3'd2) begin
            errors++;
            $display("FAIL call_over_stall: got pc %h count %0d expected 800 2",
                     bus.pc, bus.ras_count);
        end
        bus.ret_valid   = 1'b1;
        bus.call_valid  = 1'b1;
        bus.call_target = 32'hA00;
        tick();
        checks++;
        if (bus.pc !== 32'h704 || bus.ras_count !== 3'd1) begin
            errors++;
            $display("FAIL ret_beats_call: got pc %h count %0d expected 704 1",
                     bus.pc, bus.ras_count);
        end
        tick();
        clear_req();
        checks++;
        if (bus.pc !== 32'h44 || bus.ras_count !== 3'd0) begin
            errors++;
            $display("FAIL ret_chain: got pc %h count %0d expected 44 0",
                     bus.pc, bus.ras_count);
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        checks++;
        if (bus.pc_plus_inc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_inc_top: got %h expected 0", bus.pc_plus_inc);
        end
        tick();
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_plus_inc !== 32'h4) begin
            errors++;
            $display("FAIL wrap: got pc %h inc %h expected 0 4", bus.pc, bus.pc_plus_inc);
        end
    endtask

    task automatic test_reset_mid_call();
        goto_pc(32'h300);
        bus.call_valid  = 1'b1;
        bus.call_target = 32'h500;
        tick();
        reset           = 1'b1;
        bus.call_target = 32'h600;
        bus.trap_valid  = 1'b1;
        bus.trap_vector = 32'h80;
        tick();
        reset = 1'b0;
        clear_req();
        checks++;
        if (bus.pc !== 32'h100 || bus.ras_count !== 3'd0 || bus.pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_call: got pc %h count %0d valid %b expected 100 0 0",
                     bus.pc, bus.ras_count, bus.pc_valid);
        end
        bus.ret_valid    = 1'b1;
        bus.ret_fallback = 32'h777;
        tick();
        clear_req();
        checks++;
        if (bus.pc !== 32'h777 || bus.ras_underflow !== 1'b1 || bus.pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL ras_cleared: got pc %h uf %b valid %b expected 777 1 1",
                     bus.pc, bus.ras_underflow, bus.pc_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_req();
        test_reset();
        test_priority();
        test_call_ret();
        test_ras_overflow();
        test_back_to_back();
        test_wrap();
        test_reset_mid_call();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
